// File: rtl/cpu_run_monitor_if.sv
// Snoop, configuration and result signals of the CPU run monitor.
// master: CPU/bench side driving the snoop and table ports.
// slave:  the monitor itself.
// The wr_count/r0_write ports exist only when MON_WCOUNT_EN is defined.
interface cpu_run_monitor_if #(
  parameter int WIDTH      = 32,
  parameter int NUM_CHECKS = 8,
  parameter int CNT_W      = 16
);
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic             start;
  logic [WIDTH-1:0] pc;
  logic             reg_we;
  logic [4:0]       reg_waddr;
  logic [WIDTH-1:0] reg_wdata;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic             cfg_valid;
  logic [4:0]       cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [IDX_W-1:0] mismatch_idx;
  logic [WIDTH-1:0] mismatch_data;
`ifdef MON_WCOUNT_EN
  logic [CNT_W-1:0] wr_count;
  logic             r0_write;
`endif

  modport master (
    output start, pc, reg_we, reg_waddr, reg_wdata,
    output cfg_we, cfg_idx, cfg_valid, cfg_addr, cfg_data,
    input  busy, done, pass, timeout, cycle_count, mismatch_idx, mismatch_data
`ifdef MON_WCOUNT_EN
    , input wr_count, r0_write
`endif
  );

  modport slave (
    input  start, pc, reg_we, reg_waddr, reg_wdata,
    input  cfg_we, cfg_idx, cfg_valid, cfg_addr, cfg_data,
    output busy, done, pass, timeout, cycle_count, mismatch_idx, mismatch_data
`ifdef MON_WCOUNT_EN
    , output wr_count, r0_write
`endif
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run monitor for the single-cycle CPU. Shadows the register file from the
// write port, detects halt (PC unchanged for HALT_CYCLES cycles) or timeout,
// then walks the expected-value table one entry per cycle and reports the
// result. Optional write statistics (wr_count, r0_write) under MON_WCOUNT_EN.
module cpu_run_monitor #(
  parameter int WIDTH       = 32,
  parameter int NUM_CHECKS  = 8,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 4096,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  cpu_run_monitor_if.slave mon
);
  localparam int IDX_W   = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int STUCK_W = $clog2(HALT_CYCLES + 1);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_CHECKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   shadow    [32];
  logic               tbl_valid [NUM_CHECKS];
  logic [4:0]         tbl_addr  [NUM_CHECKS];
  logic [WIDTH-1:0]   tbl_data  [NUM_CHECKS];

  logic [WIDTH-1:0]   prev_pc;
  logic [STUCK_W-1:0] stuck, stuck_nxt;
  logic [CNT_W-1:0]   cycle_cnt, cnt_nxt;
  logic [IDX_W-1:0]   chk_idx;
  logic               found, done_q, pass_q, timeout_q;
  logic [IDX_W-1:0]   midx_q;
  logic [WIDTH-1:0]   mdata_q;
  logic               idle_like, halt_now, tmo_now, mm_now, cfg_ok;
`ifdef MON_WCOUNT_EN
  logic [CNT_W-1:0]   wr_count_q;
  logic               r0_write_q;
`endif

  // Run-exit and per-entry compare conditions
  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE);
    stuck_nxt = (mon.pc == prev_pc) ? stuck + 1'b1 : '0;
    cnt_nxt   = cycle_cnt + 1'b1;
    halt_now  = (state == S_RUN) && (stuck_nxt == STUCK_LAST);
    // halt takes priority over a coincident timeout
    tmo_now   = (state == S_RUN) && !halt_now && (cnt_nxt == CNT_LAST);
    mm_now    = (state == S_CHECK) && !found && tbl_valid[chk_idx] &&
                (shadow[tbl_addr[chk_idx]] != tbl_data[chk_idx]);
    cfg_ok    = mon.cfg_we && idle_like && (int'(mon.cfg_idx) < NUM_CHECKS);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and busy decode
  always_comb begin
    state_nxt = state;
    mon.busy  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: if (mon.start) state_nxt = S_RUN;
      S_RUN: begin
        mon.busy = 1'b1;
        if (halt_now || tmo_now) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        mon.busy = 1'b1;
        if (chk_idx == IDX_LAST) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shadow registers, expected table, counters and result latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) shadow[i] <= '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_addr[i]  <= '0;
        tbl_data[i]  <= '0;
      end
      prev_pc   <= '0;
      stuck     <= '0;
      cycle_cnt <= '0;
      chk_idx   <= '0;
      found     <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      midx_q    <= '0;
      mdata_q   <= '0;
`ifdef MON_WCOUNT_EN
      wr_count_q <= '0;
      r0_write_q <= 1'b0;
`endif
    end else begin
      if (cfg_ok) begin
        tbl_valid[mon.cfg_idx] <= mon.cfg_valid;
        tbl_addr[mon.cfg_idx]  <= mon.cfg_addr;
        tbl_data[mon.cfg_idx]  <= mon.cfg_data;
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (mon.start) begin
            for (int unsigned i = 0; i < 32; i++) shadow[i] <= '0;
            prev_pc   <= mon.pc;
            stuck     <= '0;
            cycle_cnt <= '0;
            chk_idx   <= '0;
            found     <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            midx_q    <= '0;
            mdata_q   <= '0;
`ifdef MON_WCOUNT_EN
            wr_count_q <= '0;
            r0_write_q <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          cycle_cnt <= cnt_nxt;
          stuck     <= stuck_nxt;
          prev_pc   <= mon.pc;
          if (mon.reg_we && (mon.reg_waddr != 5'd0)) shadow[mon.reg_waddr] <= mon.reg_wdata;
          if (tmo_now) timeout_q <= 1'b1;
`ifdef MON_WCOUNT_EN
          if (mon.reg_we && (mon.reg_waddr != 5'd0)) wr_count_q <= wr_count_q + 1'b1;
          if (mon.reg_we && (mon.reg_waddr == 5'd0)) r0_write_q <= 1'b1;
`endif
        end
        S_CHECK: begin
          if (mm_now) begin
            found   <= 1'b1;
            midx_q  <= chk_idx;
            mdata_q <= shadow[tbl_addr[chk_idx]];
          end
          if (chk_idx == IDX_LAST) begin
            chk_idx <= '0;
            done_q  <= 1'b1;
            pass_q  <= !(found || mm_now) && !timeout_q;
          end else begin
            chk_idx <= chk_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result outputs
  always_comb begin
    mon.done          = done_q;
    mon.pass          = pass_q;
    mon.timeout       = timeout_q;
    mon.cycle_count   = cycle_cnt;
    mon.mismatch_idx  = midx_q;
    mon.mismatch_data = mdata_q;
`ifdef MON_WCOUNT_EN
    mon.wr_count      = wr_count_q;
    mon.r0_write      = r0_write_q;
`endif
  end
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed CPU traces plus a run-level model that
// is compared against every output on each falling clock edge.
module tb_cpu_run_monitor;
  localparam int WIDTH = 32, NUM_CHECKS = 8, HALT_CYCLES = 4, MAX_CYCLES = 64, CNT_W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_run_monitor_if #(.WIDTH(WIDTH), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W)) bus ();

  cpu_run_monitor #(
    .WIDTH(WIDTH), .NUM_CHECKS(NUM_CHECKS), .HALT_CYCLES(HALT_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .mon(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- run-level model ----------------
  bit          m_running, m_to, m_done, m_pass, m_r0;
  int          m_check_left, m_checked, m_cycles, m_first_mm, m_wr, m_hist_n;
  logic [31:0] m_mm_data;
  logic [31:0] m_hist [HALT_CYCLES];
  logic [31:0] m_shadow [32];
  bit          m_tbl_valid [NUM_CHECKS];
  logic [4:0]  m_tbl_addr [NUM_CHECKS];
  logic [31:0] m_tbl_data [NUM_CHECKS];

  function automatic void find_mm(input bit wen, input logic [4:0] wa, input logic [31:0] wd,
                                  output int idx, output logic [31:0] val);
    logic [31:0] v;
    idx = -1;
    val = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      v = (wen && wa != 0 && wa == m_tbl_addr[i]) ? wd : m_shadow[m_tbl_addr[i]];
      if (idx < 0 && m_tbl_valid[i] && v != m_tbl_data[i]) begin
        idx = i;
        val = v;
      end
    end
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit          idle, stk;
    int          cyc_n, fi;
    logic [31:0] fv;
    if (!reset) begin
      m_running <= 0; m_to <= 0; m_done <= 0; m_pass <= 0; m_r0 <= 0;
      m_check_left <= 0; m_checked <= 0; m_cycles <= 0; m_first_mm <= -1;
      m_wr <= 0; m_hist_n <= 0; m_mm_data <= '0;
      for (int i = 0; i < 32; i++) m_shadow[i] <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) m_tbl_valid[i] <= 0;
    end else begin
      idle = !m_running && m_check_left == 0;
      if (idle && bus.cfg_we && int'(bus.cfg_idx) < NUM_CHECKS) begin
        m_tbl_valid[bus.cfg_idx] <= bus.cfg_valid;
        m_tbl_addr[bus.cfg_idx]  <= bus.cfg_addr;
        m_tbl_data[bus.cfg_idx]  <= bus.cfg_data;
      end
      if (m_running) begin
        cyc_n = m_cycles + 1;
        m_cycles <= cyc_n;
        if (bus.reg_we && bus.reg_waddr != 0) begin
          m_shadow[bus.reg_waddr] <= bus.reg_wdata;
          m_wr <= m_wr + 1;
        end
        if (bus.reg_we && bus.reg_waddr == 0) m_r0 <= 1;
        // halted when the last HALT_CYCLES observed PCs (start PC included) are identical
        stk = (m_hist_n + 1 >= HALT_CYCLES);
        for (int k = 1; k < HALT_CYCLES; k++) if (m_hist[k] != bus.pc) stk = 0;
        for (int k = 0; k < HALT_CYCLES - 1; k++) m_hist[k] <= m_hist[k+1];
        m_hist[HALT_CYCLES-1] <= bus.pc;
        m_hist_n <= m_hist_n + 1;
        if (stk || cyc_n == MAX_CYCLES - 1) begin
          find_mm(bus.reg_we, bus.reg_waddr, bus.reg_wdata, fi, fv);
          m_running <= 0;
          m_to <= !stk;
          m_check_left <= NUM_CHECKS;
          m_checked <= 0;
          m_first_mm <= fi;
          m_mm_data <= fv;
        end
      end else if (m_check_left > 0) begin
        m_check_left <= m_check_left - 1;
        m_checked <= m_checked + 1;
        if (m_check_left == 1) begin
          m_done <= 1;
          m_pass <= (m_first_mm < 0) && !m_to;
        end
      end else if (bus.start) begin
        m_running <= 1; m_cycles <= 0; m_done <= 0; m_pass <= 0; m_to <= 0;
        m_first_mm <= -1; m_mm_data <= '0; m_checked <= 0; m_wr <= 0; m_r0 <= 0;
        for (int i = 0; i < 32; i++) m_shadow[i] <= '0;
        m_hist[HALT_CYCLES-1] <= bus.pc;
        m_hist_n <= 1;
      end
    end
  end

  // Output comparison against the model, every cycle
  always @(negedge clk) begin : compare
    bit vis;
    vis = (m_first_mm >= 0) && (m_first_mm < m_checked);
    check("busy", 64'(bus.busy), 64'(m_running || m_check_left != 0));
    check("done", 64'(bus.done), 64'(m_done));
    check("pass", 64'(bus.pass), 64'(m_pass));
    check("timeout", 64'(bus.timeout), 64'(m_to));
    check("cycle_count", 64'(bus.cycle_count), 64'(m_cycles));
    check("mismatch_idx", 64'(bus.mismatch_idx), vis ? 64'(m_first_mm) : 64'd0);
    check("mismatch_data", 64'(bus.mismatch_data), vis ? 64'(m_mm_data) : 64'd0);
`ifdef MON_WCOUNT_EN
    check("wr_count", 64'(bus.wr_count), 64'(m_wr));
    check("r0_write", 64'(bus.r0_write), 64'(m_r0));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] p, input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.pc = p; bus.reg_we = we; bus.reg_waddr = a; bus.reg_wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int idx, input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_valid = v; bus.cfg_addr = a; bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic load_addn(input logic [31:0] r8_exp);
    cfg(0, 1, 5'd2, 32'h37);
    cfg(1, 1, 5'd4, 32'hb);
    cfg(2, 1, 5'd8, r8_exp);
    cfg(3, 1, 5'd9, 32'h37);
    for (int i = 4; i < NUM_CHECKS; i++) cfg(i, 0, 5'd0, 32'h0);
  endtask

  task automatic wait_done(input logic [31:0] hold_pc);
    int n = 0;
    while (!bus.done && n < 200) begin
      drive(hold_pc, 0, 5'd0, 32'h0);
      n++;
    end
    check("wait_done", 64'(bus.done), 64'd1);
  endtask

  // addN trace: writes on RUN cycles 1-4, reaches jump-to-self (0x14) on cycle 5
  task automatic run_addn(input int restart_at);
    bus.start = 1'b1;
    drive(32'h0, 0, 5'd0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      bus.start = (c == restart_at);
      case (c)
        1: drive(32'h04, 1, 5'd4, 32'hb);
        2: drive(32'h08, 1, 5'd8, 32'hb);
        3: drive(32'h0c, 1, 5'd2, 32'h37);
        4: drive(32'h10, 1, 5'd9, 32'h37);
        default: drive(32'h14, 0, 5'd0, 32'h0);
      endcase
    end
    bus.start = 1'b0;
    wait_done(32'h14);
  endtask

  initial begin
    int t63, tdone;
    bus.start = 0; bus.pc = '0; bus.reg_we = 0; bus.reg_waddr = '0; bus.reg_wdata = '0;
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_valid = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_cycle_count", 64'(bus.cycle_count), 64'd0);
    reset = 1'b1;

    // addN: halt reached on cycle 5, declared 3 cycles later
    load_addn(32'hb);
    run_addn(0);
    check("addn_done", 64'(bus.done), 64'd1);
    check("addn_pass", 64'(bus.pass), 64'd1);
    check("addn_timeout", 64'(bus.timeout), 64'd0);
    check("addn_cycle_count", 64'(bus.cycle_count), 64'd8);

    // entry 2 now expects r8=0xc
    cfg(2, 1, 5'd8, 32'hc);
    run_addn(0);
    check("mm_pass", 64'(bus.pass), 64'd0);
    check("mm_idx", 64'(bus.mismatch_idx), 64'd2);
    check("mm_data", 64'(bus.mismatch_data), 64'hb);

    // runaway: PC never repeats
    t63 = -1; tdone = -1;
    bus.start = 1'b1;
    drive(32'h0, 0, 5'd0, 32'h0);
    bus.start = 1'b0;
    for (int i = 1; i < 300 && !bus.done; i++) begin
      drive(32'(4 * i), 0, 5'd0, 32'h0);
      if (t63 < 0 && bus.cycle_count == 16'd63) t63 = i;
      if (bus.done) tdone = i;
    end
    check("run_timeout", 64'(bus.timeout), 64'd1);
    check("run_pass", 64'(bus.pass), 64'd0);
    check("run_cycle_count", 64'(bus.cycle_count), 64'd63);
    check("run_done_latency", 64'(tdone - t63), 64'd8);

    // r0 write discarded, entry 0 checks r0 == 0
    cfg(0, 1, 5'd0, 32'h0);
    for (int i = 1; i < NUM_CHECKS; i++) cfg(i, 0, 5'd0, 32'h0);
    bus.start = 1'b1;
    drive(32'h0, 0, 5'd0, 32'h0);
    bus.start = 1'b0;
    drive(32'h4, 1, 5'd0, 32'h55);
    drive(32'h8, 1, 5'd3, 32'h12);
    wait_done(32'h8);
    check("r0_pass", 64'(bus.pass), 64'd1);
    check("r0_cycle_count", 64'(bus.cycle_count), 64'd5);
`ifdef MON_WCOUNT_EN
    check("r0_flag", 64'(bus.r0_write), 64'd1);
    check("r0_wr_count", 64'(bus.wr_count), 64'd1);
`endif

    // reset mid-RUN
    load_addn(32'hb);
    bus.start = 1'b1;
    drive(32'h0, 0, 5'd0, 32'h0);
    bus.start = 1'b0;
    drive(32'h04, 1, 5'd4, 32'hb);
    drive(32'h08, 1, 5'd8, 32'hb);
    #3 reset = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_cycle_count", 64'(bus.cycle_count), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // clean rerun with a start pulse during RUN that must be ignored
    load_addn(32'hb);
    run_addn(3);
    check("rerun_pass", 64'(bus.pass), 64'd1);
    check("rerun_cycle_count", 64'(bus.cycle_count), 64'd8);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
